// File: rtl/water_drunk.sv
// Accumulates the total water drunk from a bottle level sensor: every drop in level adds to the total.
// Optional build macro WATER_DRUNK_SATURATE_EN clamps the total at its maximum instead of wrapping.
module water_drunk #(
  parameter int LEVEL_W = 4,
  parameter int TOTAL_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] water_level,
  output logic [TOTAL_W-1:0] water_Drunk
);

  logic [LEVEL_W-1:0] prev_level;
  logic               prev_valid;
  logic [TOTAL_W-1:0] total;
  logic [TOTAL_W-1:0] total_next;
  logic [LEVEL_W-1:0] drop;
  logic [TOTAL_W:0]   sum;

  // A refill or an unchanged level contributes nothing; only falls are counted.
  always_comb begin
    drop = '0;
    if (prev_valid && (water_level < prev_level)) begin
      drop = prev_level - water_level;
    end
    sum = {1'b0, total} + (TOTAL_W+1)'(drop);
`ifdef WATER_DRUNK_SATURATE_EN
    total_next = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
`else
    total_next = sum[TOTAL_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_level <= '0;
      prev_valid <= 1'b0;
      total      <= '0;
    end else begin
      prev_level <= water_level;
      prev_valid <= 1'b1;
      total      <= total_next;
    end
  end

  assign water_Drunk = total;

endmodule

// File: tb/tb_water_drunk.sv
// Self-checking bench for water_drunk: directed sequences plus randomized levels against a reference model.
module tb_water_drunk;

  localparam int LEVEL_W = 4;
  localparam int TOTAL_W = 6;
  localparam int TOTAL_MAX = (1 << TOTAL_W) - 1;

  logic               clk;
  logic               reset;
  logic [LEVEL_W-1:0] water_level;
  logic [TOTAL_W-1:0] water_Drunk;

  logic [TOTAL_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: unbounded running total, mapped to the build's overflow rule on output.
  int m_prev  = 0;
  bit m_valid = 0;
  int m_total = 0;

  water_drunk #(.LEVEL_W(LEVEL_W), .TOTAL_W(TOTAL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .water_level (water_level),
    .water_Drunk (water_Drunk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TOTAL_W-1:0] fold(input int t);
`ifdef WATER_DRUNK_SATURATE_EN
    return (t > TOTAL_MAX) ? TOTAL_MAX[TOTAL_W-1:0] : t[TOTAL_W-1:0];
`else
    return t[TOTAL_W-1:0];
`endif
  endfunction

  task automatic model_step(input bit rst, input int level, output logic [TOTAL_W-1:0] exp);
    if (rst) begin
      m_prev  = 0;
      m_valid = 0;
      m_total = 0;
    end else begin
      if (m_valid && level < m_prev) m_total += m_prev - level;
      m_prev  = level;
      m_valid = 1;
    end
    exp = fold(m_total);
  endtask

  // Drive one edge; the expected value is either given directly or taken from the model.
  task automatic cycle(input bit rst, input int level, input bit use_model,
                       input logic [TOTAL_W-1:0] given, input string tag);
    logic [TOTAL_W-1:0] mexp;
    logic [TOTAL_W-1:0] exp;
    logic [TOTAL_W-1:0] got;
    reset       = rst;
    water_level = level[LEVEL_W-1:0];
    model_step(rst, level, mexp);
    exp_q.push_back(use_model ? mexp : given);
    @(posedge clk);
    #1;
    got = water_Drunk;
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b1, int'($urandom_range(0, 15)), 1'b0, '0, tag);
  endtask

  task automatic step(input int level, input logic [TOTAL_W-1:0] exp, input string tag);
    cycle(1'b0, level, 1'b0, exp, tag);
  endtask

  initial begin
    reset       = 1'b1;
    water_level = '0;

    // Reset then a full bottle held: nothing drunk.
    do_reset(3, "reset_state");
    for (int i = 0; i < 4; i++) step(15, 0, "full_hold");

    // Plain drinking sequence.
    do_reset(1, "reset_a");
    step(15, 0,  "drink_15");
    step(12, 3,  "drink_12");
    step(10, 5,  "drink_10");
    step(10, 5,  "drink_10_same");
    step(4,  11, "drink_4");

    // Refill adds nothing and becomes the new baseline.
    do_reset(1, "reset_b");
    step(15, 0,  "refill_15");
    step(5,  10, "refill_5");
    step(15, 10, "refill_up");
    step(10, 15, "refill_10");

    // Repeated full drops overflow the accumulator.
    do_reset(1, "reset_c");
    for (int i = 1; i <= 5; i++) begin
      step(15, fold(15 * (i - 1)), "ovf_fill");
      step(0,  fold(15 * i),       "ovf_drop");
    end
`ifdef WATER_DRUNK_SATURATE_EN
    step(0, 8'h3F, "ovf_hold");
    step(15, 8'h3F, "ovf_hold_fill");
    step(0, 8'h3F, "ovf_hold_drop");
`else
    step(0, 8'h0B, "ovf_wrap");
    step(15, 8'h0B, "ovf_wrap_fill");
    step(0, 8'h1A, "ovf_wrap_drop");
`endif

    // Reset in the middle of a run discards total and baseline.
    do_reset(1, "reset_d");
    step(15, 0,  "mid_15");
    step(0,  15, "mid_0");
    step(15, 15, "mid_refill");
    step(10, 20, "mid_20");
    do_reset(1, "mid_reset");
    step(8, 0, "post_8");
    step(6, 2, "post_6");

    // First sample of zero is a baseline, not a drop.
    do_reset(1, "reset_e");
    step(0,  0, "first_0");
    step(15, 0, "first_refill");
    step(14, 1, "first_14");

    // Randomized levels with occasional resets, checked against the model.
    do_reset(1, "reset_rand");
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 40) == 0), int'($urandom_range(0, 15)), 1'b1, '0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/water_drunk.md
WATER_DRUNK -- requirements
Module: water_drunk

Interface
REQ-001 Parameter LEVEL_W, default 4: width of the water-level sensor reading.
REQ-002 Parameter TOTAL_W, default 6: width of the consumed-water accumulator.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 water_level  input  LEVEL_W  current bottle fill level, unsigned, 0 = empty, 15 = full.
REQ-006 water_Drunk  output  TOTAL_W  total water consumed since reset, unsigned, registered.

Function
REQ-007 The block SHALL hold three registers: prev_level (LEVEL_W), prev_valid (1 bit), total (TOTAL_W); water_Drunk SHALL equal total directly, with no combinational path from water_level.
REQ-008 The block SHALL sample water_level on every rising clk edge with reset low.
REQ-009 On the first sample after reset (prev_valid = 0), the block SHALL load prev_level with the sample, set prev_valid, and leave total unchanged.
REQ-010 When prev_valid = 1 and sample < prev_level, the block SHALL add (prev_level - sample) to total.
REQ-011 When prev_valid = 1 and sample >= prev_level (refill or no change), total SHALL be unchanged.
REQ-012 prev_level SHALL load the current sample on every non-reset edge, so a refill establishes the new baseline.
REQ-013 Latency: a drop sampled at edge N SHALL be visible on water_Drunk after edge N and stable for the whole following cycle.
REQ-014 Difference arithmetic SHALL be computed LEVEL_W bits wide and zero-extended to TOTAL_W+1 bits before the add, so no intermediate truncation occurs.
REQ-015 Accumulator overflow SHALL follow REQ-020/REQ-021.
REQ-016 A drop from 15 to 0 in one cycle SHALL add exactly 15.

Reset
REQ-017 With reset high at a rising edge, the block SHALL set total = 0, prev_level = 0 and prev_valid = 0, ignoring water_level.
REQ-018 Reset asserted mid-operation SHALL discard the accumulated total and baseline at that edge, and the first post-reset sample SHALL be treated per REQ-009.
REQ-019 water_Drunk SHALL read 0 from the first edge with reset high until the first accumulated drop after reset.

Configuration
REQ-020 With macro WATER_DRUNK_SATURATE_EN defined, the block SHALL clamp total at 2^TOTAL_W-1 (63 at default) whenever the sum exceeds it, and the total SHALL then stay at that value until reset.
REQ-021 Without WATER_DRUNK_SATURATE_EN, total SHALL wrap modulo 2^TOTAL_W (sum truncated to TOTAL_W bits).

Verification
REQ-022 reset 3 cycles, then level 15 held -> water_Drunk = 0x00 every cycle.
REQ-023 After reset, levels 15,12,10,10,4 on consecutive edges -> water_Drunk 0,3,5,5,11 after the respective edges.
REQ-024 Levels 15,5,15,10 (refill in between) -> water_Drunk 0,10,10,15; the refill adds nothing.
REQ-025 Overflow: repeat 15->0 drops, 5 drops = 75 -> saturating build reads 63 (0x3F) and holds; non-saturating build reads 75 mod 64 = 11 (0x0B).
REQ-026 Reset mid-run with total = 20, then level 8 then 6 -> water_Drunk 0 after reset and after the first sample, then 2.
REQ-027 First sample after reset is 0, then 15 -> no accumulation; a next sample of 14 -> water_Drunk = 1.
